// File: rtl/cntr_timer_arb.sv
// Round-robin interval timer arbiter for two requesters sharing one free-running
// 4-bit counter; each grant enables the counter for len ticks, then pulses done.
module cntr_timer_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic       tick,
  input  logic [3:0] count,
  output logic       cnt_en,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic [3:0] elapsed,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [3:0] start_q, start_d;
  logic [3:0] len_q, len_d;
  logic [1:0] gnt_d, done_d;
  logic       win;
  logic       cur;

  // The granted requester is recoverable from the one-hot grant itself.
  assign cur       = gnt[1];
  assign elapsed   = count - start_q;
  assign busy      = (state_q != IDLE);
  assign cnt_en    = (state_q == RUN) && tick && (elapsed != len_q);
  assign state_dbg = state_q;

  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ptr_q;
    else              win = req[1];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    start_d = start_q;
    len_d   = len_q;
    gnt_d   = gnt;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          start_d = count;
          len_d   = win ? len1 : len0;
          gnt_d   = win ? 2'b10 : 2'b01;
        end
      end
      RUN: begin
        // A dropped request wins over completion in the same cycle.
        if (!req[cur]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~cur;
        end else if (elapsed == len_q) begin
          state_d = FIN;
          done_d  = gnt;
        end
      end
      FIN: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        ptr_d   = ~cur;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      start_q <= 4'd0;
      len_q   <= 4'd0;
      gnt     <= 2'b00;
      done    <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      len_q   <= len_d;
      gnt     <= gnt_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_cntr_timer_arb.sv
// Directed bench for cntr_timer_arb; models the shared counter and checks each
// step with immediate assertions against hand-computed values.
module tb_cntr_timer_arb;

  logic       clk;
  logic       rstn;
  logic [1:0] req;
  logic [3:0] len0, len1;
  logic       tick;
  logic [3:0] count;
  logic       cnt_en;
  logic [1:0] gnt, done;
  logic       busy;
  logic [3:0] elapsed;
  logic [1:0] state_dbg;

  logic       ld;
  logic [3:0] ld_val;
  logic [3:0] c0;
  logic [1:0] exp_g;
  int         n_cmp = 0;
  int         n_err = 0;

  cntr_timer_arb dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .tick      (tick),
    .count     (count),
    .cnt_en    (cnt_en),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .elapsed   (elapsed),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter: no reset, loadable only by the bench.
  always @(posedge clk) begin
    if (ld)          count <= ld_val;
    else if (cnt_en) count <= count + 4'd1;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed no finish, expected finish by 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0; tick = 1'b0;
    ld = 1'b1; ld_val = 4'd0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_gnt",    4'(gnt), 4'd0);
    chk("rst_done",   4'(done), 4'd0);
    chk("rst_busy",   4'(busy), 4'd0);
    chk("rst_cnt_en", 4'(cnt_en), 4'd0);
    chk("rst_state",  4'(state_dbg), 4'd0);

    // Single grant, len0=3 from count 5
    @(negedge clk); rstn = 1'b1; ld = 1'b1; ld_val = 4'd5;
    @(negedge clk); ld = 1'b0; req = 2'b01; len0 = 4'd3; tick = 1'b1; #1;
    chk("t1_load", count, 4'd5);
    chk("t1_idle_gnt", 4'(gnt), 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t1_gnt", 4'(gnt), 4'd1);
      chk("t1_elapsed", elapsed, 4'(i));
      chk("t1_count", count, 4'(5 + i));
      chk("t1_cnt_en", 4'(cnt_en), (i != 3) ? 4'd1 : 4'd0);
      chk("t1_done_early", 4'(done), 4'd0);
      if (i == 1) len0 = 4'd9;
    end
    @(negedge clk); #1;
    chk("t1_fin_done", 4'(done), 4'd1);
    chk("t1_fin_gnt", 4'(gnt), 4'd1);
    chk("t1_fin_cnt_en", 4'(cnt_en), 4'd0);
    req = 2'b00;
    @(negedge clk); #1;
    chk("t1_idle_gnt2", 4'(gnt), 4'd0);
    chk("t1_idle_done", 4'(done), 4'd0);
    chk("t1_idle_busy", 4'(busy), 4'd0);
    chk("t1_end_count", count, 4'd8);

    // Wrapping grant on requester 1, len1=4 from count 14
    ld = 1'b1; ld_val = 4'd14;
    @(negedge clk); ld = 1'b0; req = 2'b10; len1 = 4'd4; #1;
    chk("t2_load", count, 4'd14);
    chk("t2_idle_gnt", 4'(gnt), 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t2_gnt", 4'(gnt), 4'd2);
      chk("t2_elapsed", elapsed, 4'(i));
      chk("t2_count", count, 4'(14 + i));
      chk("t2_cnt_en", 4'(cnt_en), (i != 4) ? 4'd1 : 4'd0);
      if (i == 1) begin req = 2'b11; len0 = 4'd2; len1 = 4'd1; end
    end
    @(negedge clk); #1;
    chk("t2_fin_done", 4'(done), 4'd2);
    req = 2'b00;
    @(negedge clk); #1;
    chk("t2_idle_gnt", 4'(gnt), 4'd0);
    chk("t2_idle_done", 4'(done), 4'd0);
    @(negedge clk); #1;
    chk("t2_count_hold", count, 4'd2);
    chk("t2_no_2nd_done", 4'(done), 4'd0);

    // Alternating grants with req=11 held from reset
    rstn = 1'b0; len0 = 4'd1; len1 = 4'd1; req = 2'b11; tick = 1'b1;
    @(negedge clk); rstn = 1'b1; #1;
    chk("t3_idle_gnt", 4'(gnt), 4'd0);
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk); #1;
      chk("t3_gnt", 4'(gnt), 4'(exp_g));
      chk("t3_cnt_en_on", 4'(cnt_en), 4'd1);
      @(negedge clk); #1;
      chk("t3_cnt_en_off", 4'(cnt_en), 4'd0);
      chk("t3_elapsed", elapsed, 4'd1);
      @(negedge clk); #1;
      chk("t3_done", 4'(done), 4'(exp_g));
      if (g == 3) req = 2'b00;
      @(negedge clk); #1;
      chk("t3_gap_gnt", 4'(gnt), 4'd0);
      chk("t3_gap_done", 4'(done), 4'd0);
    end

    // Zero-length grant: no increments
    c0 = count; len0 = 4'd0; req = 2'b01; tick = 1'b1;
    @(negedge clk); #1;
    chk("t4_gnt", 4'(gnt), 4'd1);
    chk("t4_cnt_en_a", 4'(cnt_en), 4'd0);
    chk("t4_done_a", 4'(done), 4'd0);
    @(negedge clk); #1;
    chk("t4_done", 4'(done), 4'd1);
    chk("t4_cnt_en_b", 4'(cnt_en), 4'd0);
    req = 2'b00;
    @(negedge clk); #1;
    chk("t4_idle_gnt", 4'(gnt), 4'd0);
    chk("t4_count", count, c0);

    // Abort after two increments with tick toggling
    req = 2'b01; len0 = 4'd6; tick = 1'b0;
    @(negedge clk); tick = 1'b1; c0 = count; #1;
    chk("t5_gnt", 4'(gnt), 4'd1);
    chk("t5_cnt_en_1", 4'(cnt_en), 4'd1);
    @(negedge clk); tick = 1'b0; #1;
    chk("t5_elapsed_1", elapsed, 4'd1);
    chk("t5_stall", 4'(cnt_en), 4'd0);
    chk("t5_count_1", count, 4'(c0 + 4'd1));
    @(negedge clk); tick = 1'b1; #1;
    chk("t5_elapsed_held", elapsed, 4'd1);
    chk("t5_cnt_en_2", 4'(cnt_en), 4'd1);
    @(negedge clk); tick = 1'b0; req = 2'b00; #1;
    chk("t5_elapsed_2", elapsed, 4'd2);
    chk("t5_gnt_before_abort", 4'(gnt), 4'd1);
    @(negedge clk); tick = 1'b1; #1;
    chk("t5_abort_gnt", 4'(gnt), 4'd0);
    chk("t5_abort_done", 4'(done), 4'd0);
    chk("t5_abort_busy", 4'(busy), 4'd0);
    chk("t5_abort_cnt_en", 4'(cnt_en), 4'd0);
    chk("t5_abort_count", count, 4'(c0 + 4'd2));
    req = 2'b11;
    @(negedge clk); #1;
    chk("t5_rr_gnt", 4'(gnt), 4'd2);
    req = 2'b00;
    @(negedge clk); #1;
    chk("t5_abort1_gnt", 4'(gnt), 4'd0);
    chk("t5_abort1_done", 4'(done), 4'd0);

    // Asynchronous reset mid-RUN clears ptr back to requester 0
    len0 = 4'd0; req = 2'b01;
    @(negedge clk); #1;
    chk("t6_gnt0", 4'(gnt), 4'd1);
    @(negedge clk); #1;
    chk("t6_done0", 4'(done), 4'd1);
    req = 2'b00;
    @(negedge clk); #1;
    chk("t6_idle", 4'(gnt), 4'd0);
    req = 2'b10; len1 = 4'd5;
    @(negedge clk); #1;
    chk("t6_gnt1", 4'(gnt), 4'd2);
    @(negedge clk); #1;
    chk("t6_elapsed", elapsed, 4'd1);
    chk("t6_busy", 4'(busy), 4'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_gnt", 4'(gnt), 4'd0);
    chk("t6_rst_done", 4'(done), 4'd0);
    chk("t6_rst_busy", 4'(busy), 4'd0);
    chk("t6_rst_cnt_en", 4'(cnt_en), 4'd0);
    chk("t6_rst_state", 4'(state_dbg), 4'd0);
    req = 2'b11;
    @(negedge clk); rstn = 1'b1; #1;
    chk("t6_rel_gnt", 4'(gnt), 4'd0);
    @(negedge clk); #1;
    chk("t6_first_tie", 4'(gnt), 4'd1);
    req = 2'b00;
    @(negedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cntr_timer_arb.md
CNTR_TIMER_ARB -- requirements
Module: cntr_timer_arb

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 4-bit count and 2 requesters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-requester interval request; level, held until done or dropped to abort.
REQ-005 len0  input  4  requester 0 interval length in ticks, 0..15.
REQ-006 len1  input  4  requester 1 interval length in ticks, 0..15.
REQ-007 tick  input  1  prescaler enable; one counter increment is permitted per cycle with tick=1.
REQ-008 count  input  4  current value of the shared free-running 4-bit sync counter, which has no clear or load.
REQ-009 cnt_en  output  1  count enable to the shared counter.
REQ-010 gnt  output  2  one-hot grant, registered; 00 when idle.
REQ-011 done  output  2  one-cycle completion pulse per requester, registered.
REQ-012 busy  output  1  1 when state is not IDLE.
REQ-013 elapsed  output  4  ticks counted for the current grant: (count - start_q) mod 16.

Function
REQ-014 SHALL implement the states IDLE, RUN and FIN.
REQ-015 IDLE: if any req bit is 1, SHALL grant one requester, latch start_q<=count and len_q<=len of the winner, set gnt, and go to RUN on the next edge.
REQ-016 Arbitration SHALL be round-robin: ptr names the preferred requester; if only one requests, that one wins; if both request, the requester named by ptr wins.
REQ-017 ptr SHALL be set to the other requester whenever a grant ends, whether by FIN or by abort.
REQ-018 RUN: elapsed SHALL be computed combinationally from the live count and start_q as 4-bit modulo subtraction.
REQ-019 RUN: cnt_en SHALL equal tick AND (elapsed != len_q); cnt_en SHALL be 0 in IDLE and in FIN.
REQ-020 RUN: when elapsed == len_q, the block SHALL go to FIN on the next edge; with len_q=0 it reaches FIN one cycle after the grant, with zero increments.
REQ-021 FIN: lasts exactly one cycle; done[g]=1 and gnt is held; then the block SHALL return to IDLE with gnt=00 and update ptr.
REQ-022 A new grant SHALL be possible in the IDLE cycle immediately after FIN, giving a minimum 3-cycle turnaround per grant.
REQ-023 Abort: if req[g] falls while in RUN, the block SHALL go to IDLE on the next edge with no done pulse, gnt=00, cnt_en=0 from that cycle, and ptr updated.
REQ-024 req[g] falling during FIN SHALL NOT suppress the done pulse.
REQ-025 len0/len1 changes after the grant SHALL be ignored, because len_q is latched.
REQ-026 A non-granted requester's req and len SHALL have no effect until IDLE.
REQ-027 Counter wrap (count 15->0) SHALL be transparent, because elapsed uses mod-16 arithmetic; the counter carry is not used.
REQ-028 Counter value SHALL be preserved between grants; the block never requires the counter at 0.
REQ-029 tick=0 cycles in RUN SHALL stall progress without timeout.

Reset
REQ-030 While rstn=0: state=IDLE, gnt=00, done=00, busy=0, cnt_en=0, ptr=0, start_q=0, len_q=0.
REQ-031 Reset asserted mid-RUN SHALL abort immediately and asynchronously with no done pulse; the counter's own reset is independent.
REQ-032 The first grant after reset release SHALL favour requester 0 on a tie.

Verification
REQ-033 count=5, tick=1 constant, req=01, len0=3 -> gnt=01 next cycle; cnt_en=1 for exactly 3 cycles; count ends at 8; done=01 for 1 cycle; gnt=00 after.
REQ-034 count=14, len1=4, req=10, tick=1 -> count sequence 14,15,0,1,2; elapsed reaches 4; done=10 once; count stays 2.
REQ-035 req=11 held continuously from reset, len0=len1=1 -> grants alternate 01,10,01,10; each grant yields a 1-cycle done.
REQ-036 len0=0, req=01 -> RUN then FIN with cnt_en never 1; done=01 on cycle 2 after the request; count unchanged.
REQ-037 len0=6 with tick toggling every other cycle; drop req[0] after 2 increments -> next cycle gnt=00, no done, cnt_en=0; a subsequent req=11 grants requester 1.
REQ-038 rstn pulsed low mid-RUN -> gnt, done, busy and cnt_en all 0 asynchronously; after release with req=11, requester 0 is granted.
